dfadd_run_sequencer: RTL and testbench
======================================

// Module: dfadd_run_sequencer
// PURPOSE
//  Sequencer between the user trigger and the dfadd core plus the viterbi lane array.
//  - Accepts one run request at a time and issues a single-cycle start pulse to dfadd.
//  - Waits for finish with a watchdog, then captures return_val.
//  - Distributes the 32-bit result to NUM_LANES viterbi lanes as {enable, bit} pairs for HOLD_CYCLES.
//  - Replaces the free-running &userInput trigger and the direct result fan-out.
// PARAMETERS
//  NUM_LANES    16    viterbi lanes; lane i receives result[2i+1:2i]; 2*NUM_LANES must be <= 32
//  HOLD_CYCLES  4     cycles each lane pair is presented during distribution (>=1)
//  TIMEOUT      1024  max cycles waiting for core_finish before abort (>=2)
//  CNT_W        16    width of run_count
// PORTS
//  clk              in   1          rising-edge clock
//  rst              in   1          synchronous, active-low reset
//  req_valid        in   1          run request
//  req_ready        out  1          1 in IDLE only; run accepted when req_valid & req_ready
//  stall            in   1          downstream pause; forwarded as core_waitrequest
//  core_start       out  1          to dfadd start; one-cycle pulse
//  core_waitrequest out  1          to dfadd waitrequest
//  core_finish      in   1          from dfadd finish
//  core_result      in   32         from dfadd return_val
//  lane_bit         out  NUM_LANES  to viterbi encoder_i
//  lane_en          out  NUM_LANES  to viterbi enable_encoder_i
//  busy             out  1          high in any state other than IDLE
//  done             out  1          one-cycle pulse when distribution completes
//  timeout_err      out  1          sticky abort flag
//  run_count        out  CNT_W      completed runs; wraps to 0 after all-ones
// BEHAVIOUR
//  Reset (rst==0 at posedge) forces state IDLE.
//   - Cleared to 0: every output, result register, and all counters.
//   - Reset mid-run aborts the run with no done pulse and does not increment run_count.
//  States: IDLE -> START -> WAIT -> CAPTURE -> DIST -> DONE -> IDLE.
//  IDLE: req_ready=1. On accept, go to START and clear timeout_err in the same edge.
//  START: core_start=1 for exactly this cycle; wdog cleared; then go to WAIT.
//  WAIT:
//   - wdog increments each cycle.
//   - core_finish=1 -> CAPTURE; finish takes priority over timeout on the same cycle.
//   - Else if wdog==TIMEOUT-1 -> IDLE, timeout_err<=1, no done pulse, run_count unchanged.
//   - core_finish is ignored outside WAIT.
//  CAPTURE: result<=core_result (sampled on the WAIT-exit cycle); go to DIST.
//  DIST:
//   - lane_bit[i]=result[2i] and lane_en[i]=result[2i+1], registered and held for HOLD_CYCLES cycles.
//   - Hold counter freezes while stall=1.
//   - Then all lane_en<=0 and go to DONE.
//  DONE: done=1 for one cycle; run_count increments modulo 2^CNT_W; go to IDLE.
//  lane_bit/lane_en are 0 in every state except DIST.
//  core_waitrequest=stall, registered, in all states except IDLE, where it is 0.
//  Latency, accept edge to done high (no stall, finish F cycles after START): 3+F+HOLD_CYCLES cycles.
//  req_valid during busy: ignored, not queued. A new run is accepted only on the IDLE cycle after DONE or abort.
// TESTING
//  1. Reset with rst=0 for 2 cycles -> all outputs 0, req_ready=1 after release.
//  2. req_valid, core returns 0xAAAA_5555 three cycles after start -> lanes 0-7 en=0/bit=1, lanes 8-15 en=1/bit=0;
//     held 4 cycles; done pulses; run_count=1.
//  3. Core never finishes -> abort after 1024 WAIT cycles; timeout_err=1, run_count unchanged;
//     next accept clears timeout_err.
//  4. stall=1 for 5 cycles during DIST -> lanes held 9 cycles total; core_waitrequest mirrors stall one cycle late.
//  5. finish on the same cycle as wdog==TIMEOUT-1 -> CAPTURE taken, no timeout_err.
//  6. rst=0 mid-DIST -> lanes 0 next cycle, no done pulse, run_count unchanged.
//     Separately, preload run_count=0xFFFF and complete a run -> run_count wraps to 0.

Source files
------------

// File: rtl/dfadd_run_sequencer.sv
// dfadd_run_sequencer: run request -> dfadd start/finish handshake -> viterbi lane fan-out
module dfadd_run_sequencer #(
  parameter int NUM_LANES   = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 stall,
  output logic                 core_start,
  output logic                 core_waitrequest,
  input  logic                 core_finish,
  input  logic [31:0]          core_result,
  output logic [NUM_LANES-1:0] lane_bit,
  output logic [NUM_LANES-1:0] lane_en,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     run_count
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, DIST, DONE} state_t;
  state_t state, nxt;
  logic [WD_W-1:0] wdog;
  logic [HOLD_W-1:0] hold;
  logic [31:0] result;
  logic [NUM_LANES-1:0] res_bit, res_en;
  logic accept, wd_hit, hold_hit;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign res_bit[i] = result[2*i];
    assign res_en[i]  = result[2*i+1];
  end
  assign accept   = state == IDLE && req_ready && req_valid;
  assign wd_hit   = wdog == WD_W'(TIMEOUT - 1);
  assign hold_hit = hold == HOLD_W'(HOLD_CYCLES - 1);
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = accept ? START : IDLE;
      START:   nxt = WAIT;
      WAIT:    nxt = core_finish ? CAPTURE : wd_hit ? IDLE : WAIT;
      CAPTURE: nxt = DIST;
      DIST:    nxt = (!stall && hold_hit) ? DONE : DIST;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      req_ready        <= 1'b0;
      busy             <= 1'b0;
      core_start       <= 1'b0;
      core_waitrequest <= 1'b0;
      done             <= 1'b0;
      timeout_err      <= 1'b0;
      run_count        <= '0;
      wdog             <= '0;
      hold             <= '0;
      result           <= '0;
      lane_bit         <= '0;
      lane_en          <= '0;
    end else begin
      state            <= nxt;
      req_ready        <= nxt == IDLE;
      busy             <= nxt != IDLE;
      core_start       <= nxt == START;
      core_waitrequest <= nxt != IDLE && stall;
      done             <= nxt == DONE;
      wdog             <= state == WAIT ? wdog + WD_W'(1) : '0;
      hold             <= state == DIST ? hold + HOLD_W'(!stall) : '0;
      lane_bit         <= nxt == DIST ? res_bit : '0;
      lane_en          <= nxt == DIST ? res_en : '0;
      if (state == WAIT && core_finish) result <= core_result;
      if (accept) timeout_err <= 1'b0;
      else if (state == WAIT && !core_finish && wd_hit) timeout_err <= 1'b1;
      if (nxt == DONE) run_count <= run_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dfadd_run_sequencer.sv
// tb_dfadd_run_sequencer: directed checks of the run sequencer
module tb_dfadd_run_sequencer;
  localparam int H = 4;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, stall = 1'b0, core_finish = 1'b0;
  logic [31:0] core_result = '0;
  logic req_ready, core_start, core_waitrequest, busy, done, timeout_err;
  logic [15:0] lane_bit, lane_en, run_count;
  logic req_ready_2, core_start_2, core_waitrequest_2, busy_2, done_2, timeout_err_2;
  logic [15:0] lane_bit_2, lane_en_2;
  logic [1:0] run_count_2;
  int errors = 0, checks = 0, done_cnt = 0, exp_runs = 0, exp_done = 0;
  dfadd_run_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .stall(stall),
    .core_start(core_start), .core_waitrequest(core_waitrequest), .core_finish(core_finish),
    .core_result(core_result), .lane_bit(lane_bit), .lane_en(lane_en), .busy(busy),
    .done(done), .timeout_err(timeout_err), .run_count(run_count)
  );
  dfadd_run_sequencer #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_2), .stall(stall),
    .core_start(core_start_2), .core_waitrequest(core_waitrequest_2), .core_finish(core_finish),
    .core_result(core_result), .lane_bit(lane_bit_2), .lane_en(lane_en_2), .busy(busy_2),
    .done(done_2), .timeout_err(timeout_err_2), .run_count(run_count_2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;
  function automatic logic [31:0] lanes_of(input logic [31:0] v);
    logic [15:0] e, b;
    for (int i = 0; i < 16; i++) begin
      e[i] = v[2*i+1];
      b[i] = v[2*i];
    end
    return {e, b};
  endfunction
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic start_run;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask
  task automatic finish_after(input int f, input logic [31:0] v);
    repeat (f) tick;
    core_finish = 1'b1;
    core_result = v;
    tick;
    core_finish = 1'b0;
  endtask
  task automatic full_run(input int f, input logic [31:0] v);
    start_run;
    finish_after(f, v);
    repeat (H + 2) tick;
    exp_runs++;
    exp_done++;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick;
    checks++;
    if ({req_ready, core_start, core_waitrequest, busy, done, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {req_ready, core_start, core_waitrequest, busy, done, timeout_err});
    end
    checks++;
    if ({lane_en, lane_bit, run_count} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {lane_en, lane_bit, run_count});
    end
    rst = 1'b1;
    tick;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask
  task automatic test_run;
    start_run;
    checks++;
    if ({core_start, busy, req_ready} !== 3'b110) begin
      errors++;
      $display("FAIL run_start: got %b want 110", {core_start, busy, req_ready});
    end
    tick;
    checks++;
    if (core_start !== 1'b0) begin
      errors++;
      $display("FAIL run_start_pulse: got %b want 0", core_start);
    end
    finish_after(2, 32'hAAAA_5555);
    checks++;
    if (lane_en !== 16'h0 || lane_bit !== 16'h0) begin
      errors++;
      $display("FAIL run_capture_lanes: got en=%h bit=%h want 0 0", lane_en, lane_bit);
    end
    for (int k = 0; k < H; k++) begin
      tick;
      checks++;
      if (lane_en !== 16'hFF00 || lane_bit !== 16'h00FF || done !== 1'b0) begin
        errors++;
        $display("FAIL run_dist%0d: got en=%h bit=%h done=%b want ff00 00ff 0", k, lane_en, lane_bit, done);
      end
    end
    tick;
    exp_runs++;
    exp_done++;
    checks++;
    if (done !== 1'b1 || lane_en !== 16'h0 || run_count !== 16'(exp_runs)) begin
      errors++;
      $display("FAIL run_done: got done=%b en=%h cnt=%0d want 1 0 %0d", done, lane_en, run_count, exp_runs);
    end
    tick;
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_idle: got done=%b ready=%b busy=%b want 0 1 0", done, req_ready, busy);
    end
  endtask
  task automatic test_timeout;
    start_run;
    repeat (1024) tick;
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got busy=%b err=%b want 1 0", busy, timeout_err);
    end
    tick;
    checks++;
    if ({busy, timeout_err, req_ready, done} !== 4'b0110 || run_count !== 16'(exp_runs)) begin
      errors++;
      $display("FAIL timeout_abort: got busy/err/ready/done=%b cnt=%0d want 0110 %0d", {busy, timeout_err, req_ready, done}, run_count, exp_runs);
    end
    core_finish = 1'b1;
    tick;
    core_finish = 1'b0;
    checks++;
    if (busy !== 1'b0 || done_cnt !== exp_done) begin
      errors++;
      $display("FAIL timeout_finish_ignored: got busy=%b dones=%0d want 0 %0d", busy, done_cnt, exp_done);
    end
    start_run;
    checks++;
    if (timeout_err !== 1'b0 || core_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: got err=%b start=%b want 0 1", timeout_err, core_start);
    end
    finish_after(1, 32'h0000_0001);
    repeat (H + 2) tick;
    exp_runs++;
    exp_done++;
  endtask
  task automatic test_stall;
    logic [31:0] exp;
    logic prev_s;
    exp = lanes_of(32'h1234_5678);
    prev_s = 1'b0;
    start_run;
    finish_after(2, 32'h1234_5678);
    tick;
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if ({lane_en, lane_bit} !== exp || core_waitrequest !== prev_s) begin
        errors++;
        $display("FAIL stall_dist%0d: got lanes=%h wreq=%b want %h %b", k, {lane_en, lane_bit}, core_waitrequest, exp, prev_s);
      end
      stall = k <= 5;
      prev_s = stall;
      tick;
    end
    exp_runs++;
    exp_done++;
    checks++;
    if (done !== 1'b1 || lane_en !== 16'h0 || core_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got done=%b en=%h wreq=%b want 1 0 0", done, lane_en, core_waitrequest);
    end
    stall = 1'b1;
    tick;
    tick;
    stall = 1'b0;
    checks++;
    if (core_waitrequest !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle_wreq: got wreq=%b busy=%b want 0 0", core_waitrequest, busy);
    end
  endtask
  task automatic test_finish_at_timeout;
    start_run;
    finish_after(1024, 32'hFFFF_0000);
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL edge_capture: got busy=%b err=%b want 1 0", busy, timeout_err);
    end
    tick;
    checks++;
    if (lane_en !== 16'hFF00 || lane_bit !== 16'hFF00) begin
      errors++;
      $display("FAIL edge_lanes: got en=%h bit=%h want ff00 ff00", lane_en, lane_bit);
    end
    repeat (H + 1) tick;
    exp_runs++;
    exp_done++;
    checks++;
    if (run_count !== 16'(exp_runs) || done_cnt !== exp_done || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL edge_done: got cnt=%0d dones=%0d err=%b want %0d %0d 0", run_count, done_cnt, timeout_err, exp_runs, exp_done);
    end
  endtask
  task automatic test_back_to_back;
    int starts;
    starts = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (core_start === 1'b1) starts++;
      core_finish = k == 1;
      core_result = 32'h5555_5555;
    end
    req_valid = 1'b0;
    core_finish = 1'b0;
    exp_runs++;
    exp_done++;
    checks++;
    if (starts !== 2 || core_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_starts: got starts=%0d start=%b want 2 1", starts, core_start);
    end
    finish_after(1, 32'h0);
    repeat (H + 2) tick;
    exp_runs++;
    exp_done++;
    checks++;
    if (run_count !== 16'(exp_runs) || done_cnt !== exp_done) begin
      errors++;
      $display("FAIL b2b_count: got cnt=%0d dones=%0d want %0d %0d", run_count, done_cnt, exp_runs, exp_done);
    end
  endtask
  task automatic test_reset_mid;
    start_run;
    finish_after(1, 32'hFFFF_FFFF);
    tick;
    checks++;
    if (lane_en !== 16'hFFFF || lane_bit !== 16'hFFFF) begin
      errors++;
      $display("FAIL mid_dist: got en=%h bit=%h want ffff ffff", lane_en, lane_bit);
    end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    exp_runs = 0;
    checks++;
    if ({lane_en, lane_bit} !== 32'h0 || busy !== 1'b0 || run_count !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: got lanes=%h busy=%b cnt=%0d want 0 0 0", {lane_en, lane_bit}, busy, run_count);
    end
    repeat (H + 2) tick;
    checks++;
    if (done_cnt !== exp_done || run_count !== 16'h0) begin
      errors++;
      $display("FAIL mid_no_done: got dones=%0d cnt=%0d want %0d 0", done_cnt, run_count, exp_done);
    end
  endtask
  task automatic test_wrap;
    for (int r = 0; r < 3; r++) full_run(1, 32'(r));
    checks++;
    if (run_count_2 !== 2'd3) begin
      errors++;
      $display("FAIL wrap_full: got %0d want 3", run_count_2);
    end
    full_run(2, 32'h9);
    checks++;
    if (run_count_2 !== 2'd0 || run_count !== 16'(exp_runs)) begin
      errors++;
      $display("FAIL wrap_zero: got small=%0d cnt=%0d want 0 %0d", run_count_2, run_count, exp_runs);
    end
  endtask
  initial begin
    test_reset;
    test_run;
    test_timeout;
    test_stall;
    test_finish_at_timeout;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
